// File: rtl/osd_ctrl_pkg.sv
// OSD controller shared definitions: host address map,
// configuration bundle and FSM state encoding.
package osd_ctrl_pkg;

  localparam logic [11:0] BITMAP_BASE = 12'h000;
  localparam logic [11:0] CTRL_ADDR   = 12'h800;
  localparam logic [11:0] XPOS_L      = 12'h801;
  localparam logic [11:0] XPOS_H      = 12'h802;
  localparam logic [11:0] YPOS_L      = 12'h803;
  localparam logic [11:0] YPOS_H      = 12'h804;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_RUN     = 2'd2
  } osd_state_t;

  typedef struct packed {
    logic       en;
    logic [2:0] bkgr;
    logic [9:0] xpos;
    logic [9:0] ypos;
  } osd_cfg_t;

  // 11-bit compare so lo+len never wraps back to 0
  function automatic logic in_span(
    input logic [10:0] v,
    input logic [9:0]  lo,
    input logic [10:0] len
  );
    logic [10:0] base;
    base = {1'b0, lo};
    return (v >= base) && (v < base + len);
  endfunction

endpackage

// File: rtl/osd_bitmap_ram.sv
// OSD bitmap store: single port, synchronous read,
// one cycle read latency. Contents survive reset.
module osd_bitmap_ram #(
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/osd_ctrl.sv
// On-screen display controller: host-written bitmap and
// config, per-pixel window/pixel outputs for the mixer.
module osd_ctrl
  import osd_ctrl_pkg::*;
#(
  parameter int OSD_W = 256,
  parameter int OSD_H = 64
) (
  input  logic        CLK_VIDEO,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        HSync,
  input  logic        VSync,
  input  logic        DE,
  input  logic        host_req,
  input  logic [11:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic        osd_window,
  output logic        osd_pixel,
  output logic [2:0]  osd_bkgr
);

  localparam int BPL     = OSD_W / 8;
  localparam int DEPTH   = OSD_W * OSD_H / 8;
  localparam int AW      = $clog2(DEPTH);
  localparam int BMP_LEN = (DEPTH > 2048) ? 2048 : DEPTH;

  osd_cfg_t   sh_cfg;
  osd_cfg_t   act_cfg;
  osd_state_t state;

  logic          vs_d;
  logic          de_d;
  logic          vs_rise;
  logic          de_rise;
  logic          de_fall;
  logic [9:0]    hcnt;
  logic [9:0]    vcnt;
  logic [10:0]   nx;
  logic [10:0]   rel_x;
  logic [10:0]   rel_y;
  logic          x_in;
  logic          nx_in;
  logic          y_in;
  logic          run;
  logic          pix_win;
  logic          fetch_ce;
  logic          fetch_de;
  logic          fetch;
  logic          fetch_d;
  logic [7:0]    fetch_col;
  logic [AW-1:0] fetch_addr;
  logic [7:0]    shreg;
  logic [7:0]    rdata;
  logic          host_hit;
  logic          is_bmp;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic          ack_nxt;
  logic          unused_ok;

  assign unused_ok = &{1'b0, HSync};

  assign vs_rise = VSync & ~vs_d;
  assign de_rise = DE & ~de_d;
  assign de_fall = ~DE & de_d;
  assign run     = (state == ST_RUN);

  assign nx    = {1'b0, hcnt} + 11'd1;
  assign rel_x = nx - {1'b0, act_cfg.xpos};
  assign rel_y = {1'b0, vcnt} - {1'b0, act_cfg.ypos};

  assign x_in  = in_span({1'b0, hcnt},
                         act_cfg.xpos, 11'(OSD_W));
  assign nx_in = in_span(nx, act_cfg.xpos, 11'(OSD_W));
  assign y_in  = in_span({1'b0, vcnt},
                         act_cfg.ypos, 11'(OSD_H));

  assign pix_win = run & DE & x_in & y_in;

  // fetch the byte that the next pixel starts
  assign fetch_ce = ce_pix & DE & nx_in
                  & (rel_x[2:0] == 3'd0);
  assign fetch_de = de_rise & (act_cfg.xpos == 10'd0);
  assign fetch    = run & y_in & (fetch_ce | fetch_de);

  assign fetch_col  = fetch_de ? 8'd0 : rel_x[10:3];
  assign fetch_addr = AW'(int'(rel_y) * BPL
                    + int'(fetch_col));

  assign host_hit = host_req & ~host_ack;
  assign is_bmp   = (host_addr - BITMAP_BASE)
                  < 12'(BMP_LEN);
  assign ram_we   = host_hit & is_bmp & ~fetch;
  assign ack_nxt  = host_hit & (~is_bmp | ~fetch);
  assign ram_addr = fetch ? fetch_addr
                  : AW'(host_addr - BITMAP_BASE);

  assign osd_bkgr = act_cfg.bkgr;

  osd_bitmap_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (CLK_VIDEO),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (host_wdata),
    .rdata (rdata)
  );

  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset) begin
      vs_d <= 1'b0;
      de_d <= 1'b0;
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      vs_d <= VSync;
      de_d <= DE;
      if (ce_pix) begin
        if (!DE)
          hcnt <= '0;
        else if (hcnt != 10'h3FF)
          hcnt <= hcnt + 10'd1;
      end
      if (vs_rise)
        vcnt <= '0;
      else if (de_fall && vcnt != 10'h3FF)
        vcnt <= vcnt + 10'd1;
    end
  end

  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset) begin
      sh_cfg   <= '0;
      act_cfg  <= '0;
      host_ack <= 1'b0;
    end else begin
      host_ack <= ack_nxt;
      if (host_hit && !is_bmp) begin
        unique case (1'b1)
          (host_addr == CTRL_ADDR): begin
            sh_cfg.en   <= host_wdata[0];
            sh_cfg.bkgr <= host_wdata[3:1];
          end
          (host_addr == XPOS_L):
            sh_cfg.xpos[7:0] <= host_wdata;
          (host_addr == XPOS_H):
            sh_cfg.xpos[9:8] <= host_wdata[1:0];
          (host_addr == YPOS_L):
            sh_cfg.ypos[7:0] <= host_wdata;
          (host_addr == YPOS_H):
            sh_cfg.ypos[9:8] <= host_wdata[1:0];
          default: ;
        endcase
      end
      if (vs_rise)
        act_cfg <= sh_cfg;
    end
  end

  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      fetch_d    <= 1'b0;
      shreg      <= '0;
      osd_window <= 1'b0;
      osd_pixel  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE:
          if (vs_rise && sh_cfg.en)
            state <= ST_WAIT_VS;
        ST_WAIT_VS:
          if (vs_rise)
            state <= sh_cfg.en ? ST_RUN : ST_IDLE;
        ST_RUN:
          if (vs_rise && !sh_cfg.en)
            state <= ST_IDLE;
        default:
          state <= ST_IDLE;
      endcase
      fetch_d <= fetch;
      if (fetch_d)
        shreg <= rdata;
      else if (ce_pix && pix_win)
        shreg <= {shreg[6:0], 1'b0};
      if (ce_pix) begin
        osd_window <= pix_win;
        osd_pixel  <= pix_win & shreg[7];
      end
    end
  end

endmodule

// File: tb/tb_osd_ctrl.sv
// Directed bench for osd_ctrl: bitmap display, collisions,
// shadow config, clipping, reset and disable.
module tb_osd_ctrl;

  logic        CLK_VIDEO = 1'b0;
  logic        reset;
  logic        ce_pix;
  logic        HSync;
  logic        VSync;
  logic        DE;
  logic        host_req;
  logic [11:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic        osd_window;
  logic        osd_pixel;
  logic [2:0]  osd_bkgr;

  int errors = 0;
  int checks = 0;

  logic [7:0]  m_mem [2048];
  logic        m_sh_en;
  logic [2:0]  m_sh_bk;
  logic [2:0]  m_act_bk;
  int          m_sh_x;
  int          m_sh_y;
  int          m_x;
  int          m_y;
  int          m_st;
  int          m_vcnt;
  logic [11:0] c_addr;
  logic [7:0]  c_data;

  always #5 CLK_VIDEO = ~CLK_VIDEO;

  osd_ctrl dut (
    .CLK_VIDEO  (CLK_VIDEO),
    .reset      (reset),
    .ce_pix     (ce_pix),
    .HSync      (HSync),
    .VSync      (VSync),
    .DE         (DE),
    .host_req   (host_req),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .osd_window (osd_window),
    .osd_pixel  (osd_pixel),
    .osd_bkgr   (osd_bkgr)
  );

  task automatic check(input string tag,
                       input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sh_en  = 1'b0;
    m_sh_bk  = 3'd0;
    m_act_bk = 3'd0;
    m_sh_x   = 0;
    m_sh_y   = 0;
    m_x      = 0;
    m_y      = 0;
    m_st     = 0;
    m_vcnt   = 0;
  endtask

  task automatic model_wr(input logic [11:0] a,
                          input logic [7:0] d);
    if (a < 12'h800)
      m_mem[a[10:0]] = d;
    else if (a == 12'h800) begin
      m_sh_en = d[0];
      m_sh_bk = d[3:1];
    end else if (a == 12'h801)
      m_sh_x = (m_sh_x & 32'h300) | int'(d);
    else if (a == 12'h802)
      m_sh_x = (m_sh_x & 32'hFF) | (int'(d[1:0]) << 8);
    else if (a == 12'h803)
      m_sh_y = (m_sh_y & 32'h300) | int'(d);
    else if (a == 12'h804)
      m_sh_y = (m_sh_y & 32'hFF) | (int'(d[1:0]) << 8);
  endtask

  task automatic host_wr(input logic [11:0] a,
                         input logic [7:0] d);
    int n;
    n = 0;
    host_addr  = a;
    host_wdata = d;
    host_req   = 1'b1;
    do begin
      @(posedge CLK_VIDEO); #1;
      n++;
    end while (!host_ack && n < 8);
    check($sformatf("ack_lat_%0h", a), n, 1);
    @(posedge CLK_VIDEO); #1;
    host_req = 1'b0;
    check("ack_pulse", int'(host_ack), 0);
    model_wr(a, d);
  endtask

  task automatic pix(input logic de, input logic coll);
    DE     = de;
    ce_pix = 1'b0;
    repeat (3) begin
      @(posedge CLK_VIDEO); #1;
    end
    ce_pix = 1'b1;
    if (coll) begin
      host_addr  = c_addr;
      host_wdata = c_data;
      host_req   = 1'b1;
    end
    @(posedge CLK_VIDEO); #1;
    ce_pix = 1'b0;
    if (coll) begin
      check("coll_ack_t1", int'(host_ack), 0);
      @(posedge CLK_VIDEO); #1;
      check("coll_ack_t2", int'(host_ack), 1);
      model_wr(c_addr, c_data);
      @(posedge CLK_VIDEO); #1;
      host_req = 1'b0;
      check("coll_ack_end", int'(host_ack), 0);
    end
  endtask

  task automatic chk_pix(input int p);
    int rx;
    int ry;
    int ew;
    int ep;
    logic [7:0] b;
    rx = p - m_x;
    ry = m_vcnt - m_y;
    ew = (m_st == 2 && rx >= 0 && rx < 256
          && ry >= 0 && ry < 64) ? 1 : 0;
    ep = 0;
    if (ew == 1) begin
      b  = m_mem[ry * 32 + rx / 8];
      ep = int'(b[3'(7 - rx % 8)]);
    end
    check($sformatf("win_y%0d_x%0d", m_vcnt, p),
          int'(osd_window), ew);
    check($sformatf("pix_y%0d_x%0d", m_vcnt, p),
          int'(osd_pixel), ep);
  endtask

  task automatic line(input int len, input int coll_p);
    for (int p = 0; p < len; p++) begin
      pix(1'b1, p == coll_p);
      chk_pix(p);
    end
    pix(1'b0, 1'b0);
    check("blank_win", int'(osd_window), 0);
    HSync = 1'b1;
    pix(1'b0, 1'b0);
    HSync = 1'b0;
    pix(1'b0, 1'b0);
    m_vcnt++;
  endtask

  task automatic vsync();
    VSync = 1'b1;
    pix(1'b0, 1'b0);
    pix(1'b0, 1'b0);
    VSync = 1'b0;
    pix(1'b0, 1'b0);
    case (m_st)
      0: if (m_sh_en) m_st = 1;
      1: m_st = m_sh_en ? 2 : 0;
      default: if (!m_sh_en) m_st = 0;
    endcase
    m_act_bk = m_sh_bk;
    m_x      = m_sh_x;
    m_y      = m_sh_y;
    m_vcnt   = 0;
    check("bkgr", int'(osd_bkgr), int'(m_act_bk));
  endtask

  task automatic frame9(input int coll_p);
    for (int l = 0; l < 8; l++)
      line(8, -1);
    line(280, coll_p);
  endtask

  initial begin
    reset      = 1'b1;
    ce_pix     = 1'b0;
    HSync      = 1'b0;
    VSync      = 1'b0;
    DE         = 1'b0;
    host_req   = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    c_addr     = '0;
    c_data     = '0;
    model_reset();
    for (int i = 0; i < 2048; i++)
      m_mem[i] = 8'h00;
    repeat (3) @(posedge CLK_VIDEO);
    #1;
    check("rst_win", int'(osd_window), 0);
    check("rst_pix", int'(osd_pixel), 0);
    check("rst_bkgr", int'(osd_bkgr), 0);
    check("rst_ack", int'(host_ack), 0);
    reset = 1'b0;
    @(posedge CLK_VIDEO); #1;

    for (int i = 0; i < 32; i++)
      host_wr(12'(i), 8'h00);
    host_wr(12'h000, 8'hA5);
    host_wr(12'h001, 8'h3C);
    host_wr(12'h900, 8'hFF);
    host_wr(12'h805, 8'hFF);
    host_wr(12'h801, 8'd16);
    host_wr(12'h802, 8'd0);
    host_wr(12'h803, 8'd8);
    host_wr(12'h804, 8'd0);
    host_wr(12'h800, 8'h01);

    // basic pattern after two frames
    vsync();
    vsync();
    frame9(-1);

    // host write lands on a fetch cycle
    c_addr = 12'h002;
    c_data = 8'h81;
    vsync();
    frame9(23);

    // shadowed xpos change mid-frame
    vsync();
    for (int l = 0; l < 8; l++)
      line(8, -1);
    host_wr(12'h801, 8'd100);
    line(280, -1);
    vsync();
    frame9(-1);

    // clip at the right edge of a 1000 pixel line
    host_wr(12'h801, 8'h84);
    host_wr(12'h802, 8'h03);
    host_wr(12'h803, 8'h00);
    vsync();
    line(1000, -1);

    // xpos 0 fetches on DE rise, bkgr visible
    host_wr(12'h801, 8'h00);
    host_wr(12'h802, 8'h00);
    host_wr(12'h800, 8'h0B);
    vsync();
    line(20, -1);

    // asynchronous reset while displaying
    vsync();
    for (int p = 0; p < 5; p++) begin
      pix(1'b1, 1'b0);
      chk_pix(p);
    end
    #2 reset = 1'b1;
    #1;
    check("mid_rst_win", int'(osd_window), 0);
    check("mid_rst_pix", int'(osd_pixel), 0);
    check("mid_rst_bkgr", int'(osd_bkgr), 0);
    check("mid_rst_ack", int'(host_ack), 0);
    DE     = 1'b0;
    ce_pix = 1'b0;
    repeat (2) @(posedge CLK_VIDEO);
    #1;
    reset = 1'b0;
    model_reset();
    vsync();
    line(20, -1);
    host_wr(12'h800, 8'h01);
    vsync();
    line(20, -1);
    vsync();
    line(20, -1);

    // disable holds until the next VSync
    vsync();
    host_wr(12'h800, 8'h00);
    line(20, -1);
    vsync();
    line(20, -1);
    vsync();
    line(20, -1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/osd_ctrl.md
OSD_CTRL -- requirements
Module: osd_ctrl

Interface
REQ-001 SHALL have parameter OSD_W, default 256, meaning OSD width in pixels (multiple of 8).
REQ-002 SHALL have parameter OSD_H, default 64, meaning OSD height in lines.
REQ-003 SHALL have port CLK_VIDEO, input, 1 bit: the only clock, the same one that drives the video mixer.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-005 SHALL have port ce_pix, input, 1 bit: output pixel clock enable from the mixer, at most 1 cycle in 4.
REQ-006 SHALL have ports HSync and VSync, input, 1 bit each: positive sync pulses.
REQ-007 SHALL have port DE, input, 1 bit: active video.
REQ-008 SHALL have ports host_req (input, 1), host_addr (input, 12), host_wdata (input, 8) and host_ack (output, 1): the host write handshake.
REQ-009 SHALL have ports osd_window, osd_pixel (output, 1 each) and osd_bkgr (output, 3): the inputs of the mixer OSD overlay.

Function
REQ-010 SHALL hold the bitmap in internal RAM: OSD_W*OSD_H/8 bytes, with pixel (x,y) at bit 7-(x mod 8) of byte y*(OSD_W/8)+x/8.
REQ-011 SHALL decode host addresses as follows:
- 0x000-0x7FF: bitmap bytes.
- 0x800: ctrl, bit0 enable, bits3:1 bkgr.
- 0x801/0x802: xpos[7:0]/[9:8].
- 0x803/0x804: ypos[7:0]/[9:8].
- All other addresses: writes acknowledged and discarded.
REQ-012 SHALL hold host_req, host_addr and host_wdata stable from the master until host_ack; host_ack SHALL be a single-cycle pulse, and host_req SHALL be deasserted the cycle after host_ack.
REQ-013 SHALL arbitrate RAM access with fixed priority, video fetch over host:
- A host bitmap write SHALL complete in a cycle with no fetch.
- host_ack SHALL follow in the next cycle.
- Maximum latency from host_req to host_ack is 3 cycles.
REQ-014 SHALL ack config writes 1 cycle after host_req, with no arbitration; they go to shadow registers.
REQ-015 SHALL copy the shadow registers to the active registers on every VSync rising edge.
REQ-016 SHALL keep hcnt (10 bits) as follows:
- Cleared on a ce_pix where DE=0.
- Incremented on a ce_pix where DE=1.
- Saturates at 1023.
REQ-017 SHALL keep vcnt (10 bits) as follows:
- Cleared on the VSync rising edge.
- Incremented on each DE falling edge.
- Saturates at 1023.
REQ-018 SHALL define the window as xpos<=hcnt<xpos+OSD_W and ypos<=vcnt<ypos+OSD_H, evaluated at 11-bit width so the region clips without wrap.
REQ-019 SHALL use a three-state FSM:
- IDLE: active enable=0, outputs 0.
- WAIT_VS: entered when enable is latched; waits for the next VSync rising edge.
- RUN: displays the window.
- RUN->IDLE when enable is latched 0 at a VSync rising edge.
- Any state->IDLE on reset.
REQ-020 SHALL, in RUN, issue a bitmap fetch on the ce_pix where hcnt==xpos-1 (for col 0) and where the relative column mod 8 == 7.
- For xpos=0, col 0 SHALL be fetched on the DE rising edge.
- The data SHALL be loaded into an 8-bit shift register before the next ce_pix.
REQ-021 SHALL register osd_window and osd_pixel, updated 1 CLK_VIDEO after each ce_pix.
- osd_pixel=0 whenever osd_window=0.
REQ-022 SHALL drive osd_bkgr from the active bkgr register.
REQ-023 SHALL display bitmap data written during the frame from the next fetch of the affected byte; tearing is accepted.

Reset
REQ-024 SHALL, on reset, drive osd_window=0, osd_pixel=0, osd_bkgr=0 and host_ack=0.
REQ-025 SHALL, on reset, clear the shadow and active registers, clear hcnt and vcnt, and put the FSM in IDLE.
REQ-026 SHALL NOT clear the RAM contents on reset.
REQ-027 SHALL, if reset is asserted mid-transaction, abandon the pending host write, and the master SHALL reissue it.

Structure
REQ-028 SHALL place the following in the shared video package: the address map constants (BITMAP_BASE, CTRL_ADDR, XPOS_L/H, YPOS_L/H) and the FSM state encoding.
REQ-029 SHALL implement the RAM as one sub-module, osd_bitmap_ram: single-port, synchronous read, 1-cycle latency.

Verification
REQ-030 SHALL have a bench scenario for the basic pattern:
- Stimulus: write 0xA5 to 0x000; set xpos=16, ypos=8, enable=1; run 2 frames.
- Response: on line 8, pixels 16..23 give osd_pixel 1,0,1,0,0,1,0,1, and osd_window=1 for pixels 16..271.
REQ-031 SHALL have a bench scenario for fetch/host collision:
- Stimulus: host_req on the same cycle as a fetch.
- Response: host_ack 2 cycles after host_req, and the pixel stream is uncorrupted.
REQ-032 SHALL have a bench scenario for the config shadow:
- Stimulus: write xpos=100 mid-frame.
- Response: window start is unchanged until after the next VSync, then moves to 100.
REQ-033 SHALL have a bench scenario for clipping:
- Stimulus: xpos=900 with a 1000-pixel line.
- Response: osd_window is high for pixels 900..999 only, with no wrap to column 0.
REQ-034 SHALL have a bench scenario for mid-frame reset:
- Stimulus: reset asserted while in RUN.
- Response: all outputs 0 asynchronously, FSM IDLE, and no display until enable is rewritten and a VSync occurs.
REQ-035 SHALL have a bench scenario for disable:
- Stimulus: write enable=0.
- Response: osd_window stays active until the VSync rising edge, then remains 0.
